usb_desc_streamer: RTL

USB_DESC_STREAMER -- requirements
Module: usb_desc_streamer

---
 rtl/usb_desc_streamer_pkg.sv | 83 ++++++++
 rtl/usb_desc_rom.sv | 29 ++
 rtl/usb_desc_streamer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_desc_streamer_pkg.sv
// Shared types, USB descriptor codes, ROM layout and descriptor contents for the EP0 descriptor streamer.
// The ROM image is built from the packed tables below; the device descriptor's bMaxPacketSize0 byte is patched in per instance.
package usb_desc_streamer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_IN,
    SEND,
    WAIT_ACK,
    STALL
  } state_e;

  localparam logic [7:0] DT_DEVICE = 8'h01;
  localparam logic [7:0] DT_CONFIG = 8'h02;
  localparam logic [7:0] DT_STRING = 8'h03;

  // ROM layout: device | config set | string 0 | strings 1..NUM_STR-1 (fixed 6-byte records)
  localparam int DEV_OFF   = 0;
  localparam int DEV_LEN   = 18;
  localparam int CFG_OFF   = 18;
  localparam int CFG_LEN   = 32;
  localparam int STR0_OFF  = 50;
  localparam int STR0_LEN  = 4;
  localparam int STRN_OFF  = 54;
  localparam int STRN_LEN  = 6;
  localparam int DEV_MPKT_BYTE = 7;

  localparam logic [8*DEV_LEN-1:0] DEV_DESC =
    144'h12_01_10_01_00_00_00_00_B4_04_F0_00_01_01_00_00_00_01;
  localparam logic [8*CFG_LEN-1:0] CFG_DESC =
    256'h09_02_20_00_01_01_00_40_05_09_04_00_00_02_FF_00_00_00_07_05_82_02_08_00_00_07_05_06_02_08_00_00;
  localparam logic [8*STR0_LEN-1:0] STR0_DESC = 32'h04_03_09_04;

  typedef struct packed {
    logic       hit;
    logic [7:0] off;
    logic [7:0] len;
  } desc_loc_t;

  function automatic desc_loc_t desc_lookup(input logic [7:0] dtype, input logic [7:0] idx,
                                            input int num_str);
    desc_loc_t loc;
    loc = '0;
    if (dtype == DT_DEVICE && idx == 8'd0) begin
      loc = '{hit: 1'b1, off: 8'(DEV_OFF), len: 8'(DEV_LEN)};
    end else if (dtype == DT_CONFIG && idx == 8'd0) begin
      loc = '{hit: 1'b1, off: 8'(CFG_OFF), len: 8'(CFG_LEN)};
    end else if (dtype == DT_STRING && idx == 8'd0) begin
      loc = '{hit: 1'b1, off: 8'(STR0_OFF), len: 8'(STR0_LEN)};
    end else if (dtype == DT_STRING && int'(idx) < num_str) begin
      loc = '{hit: 1'b1, off: 8'(STRN_OFF + (int'(idx) - 1) * STRN_LEN), len: 8'(STRN_LEN)};
    end
    return loc;
  endfunction

  // Strings 1.. are UTF-16LE "S<n>" with n the ASCII digit of the index
  function automatic logic [7:0] rom_byte(input int addr, input logic [7:0] mpkt);
    logic [7:0] b;
    int         s;
    s = 0;
    if (addr == DEV_OFF + DEV_MPKT_BYTE) begin
      b = mpkt;
    end else if (addr < CFG_OFF) begin
      b = DEV_DESC[8*(DEV_LEN-1-(addr-DEV_OFF)) +: 8];
    end else if (addr < STR0_OFF) begin
      b = CFG_DESC[8*(CFG_LEN-1-(addr-CFG_OFF)) +: 8];
    end else if (addr < STRN_OFF) begin
      b = STR0_DESC[8*(STR0_LEN-1-(addr-STR0_OFF)) +: 8];
    end else begin
      s = (addr - STRN_OFF) % STRN_LEN;
      case (s)
        0:       b = 8'(STRN_LEN);
        1:       b = DT_STRING;
        2:       b = 8'h53;
        4:       b = 8'(32'h31 + (addr - STRN_OFF) / STRN_LEN);
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/usb_desc_rom.sv
// Synchronous descriptor ROM, one byte per read with one-cycle latency.
// The output register only loads when rd_en is high, so the reader can stall without losing a byte.
module usb_desc_rom
  import usb_desc_streamer_pkg::*;
#(
  parameter int ROM_AW  = 7,
  parameter int MAX_PKT = 8
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ROM_AW-1:0] addr,
  output logic [7:0]        rd_dat
);

  logic [7:0] rd_dat_d;
  logic [7:0] rd_dat_q;

  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) rd_dat_d = rom_byte(int'(addr), 8'(MAX_PKT));
  end

  always_ff @(posedge clk) begin
    rd_dat_q <= rd_dat_d;
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/usb_desc_streamer.sv
// Streams USB descriptors from ROM over EP0 as MAX_PKT packets with IN/ACK/retry handshakes, ZLP termination and stalls.
// First beat appears 3 cycles after inToken; outReady low freezes the output beat and the ROM prefetch stage.
module usb_desc_streamer
  import usb_desc_streamer_pkg::*;
#(
  parameter int MAX_PKT = 8,
  parameter int ROM_AW  = 7,
  parameter int NUM_STR = 3
) (
  input  logic        useClk,
  input  logic        useRstN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [7:0]  reqType,
  input  logic [7:0]  reqIndex,
  input  logic [15:0] reqLength,
  input  logic        inToken,
  input  logic        ack,
  input  logic        retry,
  input  logic        abort,
  output logic        outValid,
  input  logic        outReady,
  output logic [7:0]  outData,
  output logic        outLast,
  output logic        outZlp,
  output logic        stall,
  output logic        done,
  output logic        busy
);

  localparam logic [15:0] MPKT = 16'(MAX_PKT);

  state_e      state_q, state_d;
  logic [7:0]  req_type_q, req_type_d;
  logic [7:0]  req_idx_q, req_idx_d;
  logic [15:0] req_len_q, req_len_d;
  logic [7:0]  base_q, base_d;
  logic [15:0] xfer_len_q, xfer_len_d;
  logic [15:0] pkt_start_q, pkt_start_d;
  logic [15:0] pkt_len_q, pkt_len_d;
  logic        zlp_pkt_q, zlp_pkt_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] emit_cnt_q, emit_cnt_d;
  logic        rom_vld_q, rom_vld_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        out_zlp_q, out_zlp_d;
  logic        stall_q, stall_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        req_ready_q, req_ready_d;

  desc_loc_t   loc;
  logic [15:0] remaining;
  logic [15:0] next_start;
  logic        b_free, a_move, issue, zlp_owed, rom_en;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]  rom_dat;

  assign rom_addr = ROM_AW'({8'd0, base_q} + pkt_start_q + fetch_cnt_q);

  usb_desc_rom #(.ROM_AW(ROM_AW), .MAX_PKT(MAX_PKT)) u_rom (
    .clk    (useClk),
    .rd_en  (rom_en),
    .addr   (rom_addr),
    .rd_dat (rom_dat)
  );

  always_comb begin
    state_d     = state_q;
    req_type_d  = req_type_q;
    req_idx_d   = req_idx_q;
    req_len_d   = req_len_q;
    base_d      = base_q;
    xfer_len_d  = xfer_len_q;
    pkt_start_d = pkt_start_q;
    pkt_len_d   = pkt_len_q;
    zlp_pkt_d   = zlp_pkt_q;
    fetch_cnt_d = fetch_cnt_q;
    emit_cnt_d  = emit_cnt_q;
    rom_vld_d   = rom_vld_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_zlp_d   = out_zlp_q;
    stall_d     = 1'b0;
    done_d      = 1'b0;
    rom_en      = 1'b0;

    loc        = desc_lookup(req_type_q, req_idx_q, NUM_STR);
    remaining  = xfer_len_q - pkt_start_q;
    next_start = pkt_start_q + pkt_len_q;
    // Two-stage pipe: ROM register (stage A) feeds the output register (stage B)
    b_free     = !out_valid_q || outReady;
    a_move     = rom_vld_q && b_free;
    issue      = (fetch_cnt_q < pkt_len_q) && (!rom_vld_q || a_move);
    zlp_owed   = (xfer_len_q != 16'd0) && ((xfer_len_q & (MPKT - 16'd1)) == 16'd0) &&
                 (xfer_len_q < req_len_q);

    case (state_q)
      IDLE: begin
        if (reqValid) begin
          req_type_d = reqType;
          req_idx_d  = reqIndex;
          req_len_d  = reqLength;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (loc.hit) begin
          base_d      = loc.off;
          xfer_len_d  = (req_len_q < {8'd0, loc.len}) ? req_len_q : {8'd0, loc.len};
          pkt_start_d = 16'd0;
          state_d     = WAIT_IN;
        end else begin
          stall_d = 1'b1;
          state_d = STALL;
        end
      end
      STALL: state_d = IDLE;
      WAIT_IN: begin
        if (inToken) begin
          pkt_len_d   = (remaining < MPKT) ? remaining : MPKT;
          zlp_pkt_d   = (remaining == 16'd0);
          fetch_cnt_d = 16'd0;
          emit_cnt_d  = 16'd0;
          rom_vld_d   = 1'b0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (zlp_pkt_q) begin
          if (!out_valid_q) begin
            out_valid_d = 1'b1;
            out_data_d  = 8'h00;
            out_last_d  = 1'b1;
            out_zlp_d   = 1'b1;
          end else if (outReady) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_zlp_d   = 1'b0;
            state_d     = WAIT_ACK;
          end
        end else begin
          if (issue) begin
            rom_en      = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 16'd1;
          end
          if (a_move) begin
            out_valid_d = 1'b1;
            out_data_d  = rom_dat;
            out_last_d  = (emit_cnt_q + 16'd1 == pkt_len_q);
            emit_cnt_d  = emit_cnt_q + 16'd1;
          end else if (out_valid_q && outReady) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (out_last_q) state_d = WAIT_ACK;
          end
          rom_vld_d = issue || (rom_vld_q && !a_move);
        end
      end
      WAIT_ACK: begin
        if (retry) begin
          state_d = WAIT_IN;
        end else if (ack) begin
          pkt_start_d = next_start;
          if (next_start == xfer_len_q && (zlp_pkt_q || !zlp_owed)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_IN;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_zlp_d   = 1'b0;
      rom_vld_d   = 1'b0;
      stall_d     = 1'b0;
      done_d      = 1'b0;
    end

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge useClk or negedge useRstN) begin
    if (!useRstN) begin
      state_q     <= IDLE;
      req_type_q  <= 8'd0;
      req_idx_q   <= 8'd0;
      req_len_q   <= 16'd0;
      base_q      <= 8'd0;
      xfer_len_q  <= 16'd0;
      pkt_start_q <= 16'd0;
      pkt_len_q   <= 16'd0;
      zlp_pkt_q   <= 1'b0;
      fetch_cnt_q <= 16'd0;
      emit_cnt_q  <= 16'd0;
      rom_vld_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
      out_zlp_q   <= 1'b0;
      stall_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_type_q  <= req_type_d;
      req_idx_q   <= req_idx_d;
      req_len_q   <= req_len_d;
      base_q      <= base_d;
      xfer_len_q  <= xfer_len_d;
      pkt_start_q <= pkt_start_d;
      pkt_len_q   <= pkt_len_d;
      zlp_pkt_q   <= zlp_pkt_d;
      fetch_cnt_q <= fetch_cnt_d;
      emit_cnt_q  <= emit_cnt_d;
      rom_vld_q   <= rom_vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_zlp_q   <= out_zlp_d;
      stall_q     <= stall_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign reqReady = req_ready_q;
  assign outValid = out_valid_q;
  assign outData  = out_data_q;
  assign outLast  = out_last_q;
  assign outZlp   = out_zlp_q;
  assign stall    = stall_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule
